rom_reader: RTL and testbench

Sequencer that sits directly upstream of the team's 8x4 lookup ROM. It drives the ROM address, captures the returned word, and streams the words out over a valid/ready handshake. A transfer is a burst of `count` consecutive addresses starting at `start_addr`, wrapping modulo the ROM depth. It lets downstream logic consume ROM contents without owning address generation.

---
 rtl/rom_pkg.sv | 14 +
 rtl/rom_reader_wrap_counter.sv | 35 +++
 rtl/rom_reader.sv | 148 ++++++++++++++
 tb/tb_rom_reader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared definitions for the ROM reader: FSM state encoding and default ROM geometry.
package rom_pkg;

  localparam int AW_DEFAULT = 3;
  localparam int DW_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/rom_reader_wrap_counter.sv
// wrap_counter: loadable AW-bit address counter; increments wrap modulo 2^AW.
module wrap_counter #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [AW-1:0] load_val_i,
  input  logic          inc_i,
  output logic [AW-1:0] count_o
);

  logic [AW-1:0] count_q, count_d;

  // Load has priority so a new burst always starts from its own base address.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = count_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/rom_reader.sv
// rom_reader: bursts consecutive ROM words out over valid/ready.
// Optional running checksum port enabled by defining ROM_READER_CHECKSUM_EN.
module rom_reader
  import rom_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr
`ifdef ROM_READER_CHECKSUM_EN
 ,output logic [DW+AW:0] checksum
`endif
);

  state_e        state_q, state_d;
  logic [AW:0]   remaining_q, remaining_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          addr_load, addr_inc;
  logic          handshake;

  assign handshake = out_valid_q && out_ready;

  wrap_counter #(.AW(AW)) u_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (addr_load),
    .load_val_i (start_addr),
    .inc_i      (addr_inc),
    .count_o    (rom_addr)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    addr_load   = 1'b0;
    addr_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            addr_load   = 1'b1;
            remaining_d = count;
            state_d     = READ;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        out_data_d  = rom_data;
        out_addr_d  = rom_addr;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          if (remaining_q == (AW+1)'(1)) begin
            state_d = DONE;
          end else begin
            remaining_d = remaining_q - (AW+1)'(1);
            addr_inc    = 1'b1;
            state_d     = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // busy/done are registered copies of the next-state decode, so they stay glitch-free.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;

`ifdef ROM_READER_CHECKSUM_EN
  logic [DW+AW:0] checksum_q, checksum_d;

  // Width DW+AW+1 holds (2^(AW+1)-1) * (2^DW-1), the largest possible burst sum.
  always_comb begin
    checksum_d = checksum_q;
    if (state_q == IDLE && start) begin
      checksum_d = '0;
    end else if (handshake) begin
      checksum_d = checksum_q + {{(AW+1){1'b0}}, out_data_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_rom_reader.sv
// Scoreboard bench for rom_reader driving an 8x4 ROM that holds 2*addr.
// Checksum checks are active when ROM_READER_CHECKSUM_EN is defined.
module tb_rom_reader;

  localparam int AW = 3;
  localparam int DW = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] startAddr = '0;
  logic [AW:0]   count = '0;
  logic          busy, done, outValid;
  logic          outReady = 1'b1;
  logic [AW-1:0] romAddr, outAddr;
  logic [DW-1:0] romData, outData;
`ifdef ROM_READER_CHECKSUM_EN
  logic [DW+AW:0] checksum;
`endif

  word_t expQ[$];
  word_t popped;
  int    checks = 0;
  int    failures = 0;
  int    expChecksum = 0;
  bit    sawValid = 1'b0;

  always #5 clk = ~clk;

  assign romData = {romAddr, 1'b0};

  rom_reader #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (startAddr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .rom_addr   (romAddr),
    .rom_data   (romData),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_data   (outData),
    .out_addr   (outAddr)
`ifdef ROM_READER_CHECKSUM_EN
   ,.checksum   (checksum)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Every handshake seen at the falling edge is matched against the oldest expected word.
  always @(negedge clk) begin
    if (outValid) sawValid = 1'b1;
    if (outValid && outReady) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_underflow", expQ.size(), 1);
      end else begin
        popped = expQ.pop_front();
        checkOutput("out_data", outData, popped.data);
        checkOutput("out_addr", outAddr, popped.addr);
      end
    end
  end

  task automatic applyStimulus(input int addr, input int cnt);
    int a;
    @(posedge clk); #1;
    start       = 1'b1;
    startAddr   = AW'(addr);
    count       = (AW+1)'(cnt);
    sawValid    = 1'b0;
    expChecksum = 0;
    for (int i = 0; i < cnt; i++) begin
      a = (addr + i) % 8;
      expQ.push_back('{addr: AW'(a), data: DW'((2 * a) % 16)});
      expChecksum += (2 * a) % 16;
    end
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
  endtask

  task automatic waitDone(input int expLatency, input bit checkLatency);
    int cycles = 0;
    bit seen = 1'b0;
    while (!seen && cycles < 200) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else cycles++;
    end
    checkOutput("done_seen", seen, 1);
    if (checkLatency) checkOutput("done_latency", cycles, expLatency);
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("busy_after_done", busy, 0);
    checkOutput("sb_drained", expQ.size(), 0);
`ifdef ROM_READER_CHECKSUM_EN
    checkOutput("checksum", checksum, expChecksum);
`endif
  endtask

  task automatic waitValid(input string tag);
    int cycles = 0;
    while (!outValid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput(tag, outValid, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_valid"}, outValid, 0);
    checkOutput({tag, "_rom_addr"}, romAddr, 0);
    checkOutput({tag, "_out_data"}, outData, 0);
    checkOutput({tag, "_out_addr"}, outAddr, 0);
`ifdef ROM_READER_CHECKSUM_EN
    checkOutput({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;

    applyStimulus(2, 3);
    waitDone(6, 1'b1);

    applyStimulus(6, 4);
    waitDone(8, 1'b1);

    applyStimulus(0, 0);
    waitDone(0, 1'b1);
    checkOutput("zero_no_valid", sawValid, 0);

    applyStimulus(0, 8);
    waitDone(16, 1'b1);

    applyStimulus(0, 9);
    waitDone(18, 1'b1);

    // Backpressure: first word (addr 5, data 10) must sit unchanged while ready is low.
    @(posedge clk); #1;
    outReady = 1'b0;
    applyStimulus(5, 2);
    waitValid("bp_valid_rise");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", outValid, 1);
      checkOutput("bp_data", outData, 10);
      checkOutput("bp_addr", outAddr, 5);
    end
    @(posedge clk); #1;
    outReady = 1'b1;
    waitDone(0, 1'b0);

    // A second start mid-burst must not add or alter any words.
    applyStimulus(1, 3);
    @(posedge clk); #1;
    start = 1'b1; startAddr = 3'd7; count = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("idle_after_burst", {outValid, busy}, 0);

    // Reset while holding a word in SEND.
    @(posedge clk); #1;
    outReady = 1'b0;
    applyStimulus(3, 4);
    waitValid("rst_valid_rise");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    outReady = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_idle", busy, 0);
    checkOutput("post_rst_no_valid", outValid, 0);
    applyStimulus(4, 2);
    waitDone(4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
